// File: rtl/gppcu_mc_lane_sequencer_if.sv
// Handshake bundle between the execute stage / shared MC unit and the lane sequencer.
// master = pipeline + MC unit side, slave = sequencer.
interface gppcu_mc_lane_sequencer_if #(
    parameter int NUM_LANES = 4,
    parameter int DBW       = 32,
    parameter int OPC_BITS  = 3
);
    logic                     iEXEC_VALID;
    logic                     iEXEC_MCOP;
    logic [OPC_BITS-1:0]      iEXEC_OPC;
    logic [NUM_LANES-1:0]     iLANE_EN;
    logic [NUM_LANES*DBW-1:0] iOPR_A;
    logic [NUM_LANES*DBW-1:0] iOPR_B;
    logic                     oMC_START;
    logic [DBW-1:0]           oMC_A;
    logic [DBW-1:0]           oMC_B;
    logic [OPC_BITS-1:0]      oMC_OPC;
    logic                     iMC_DONE;
    logic [DBW-1:0]           iMC_RESULT;
    logic [NUM_LANES*DBW-1:0] oWB_Q;
    logic [NUM_LANES-1:0]     oWB_MASK;
    logic                     oBUSY;
    logic                     oTIMEOUT;

    modport master (
        output iEXEC_VALID, iEXEC_MCOP, iEXEC_OPC, iLANE_EN, iOPR_A, iOPR_B,
               iMC_DONE, iMC_RESULT,
        input  oMC_START, oMC_A, oMC_B, oMC_OPC, oWB_Q, oWB_MASK, oBUSY, oTIMEOUT
    );

    modport slave (
        input  iEXEC_VALID, iEXEC_MCOP, iEXEC_OPC, iLANE_EN, iOPR_A, iOPR_B,
               iMC_DONE, iMC_RESULT,
        output oMC_START, oMC_A, oMC_B, oMC_OPC, oWB_Q, oWB_MASK, oBUSY, oTIMEOUT
    );
endinterface

// File: rtl/gppcu_mc_lane_sequencer.sv
// Serialises one shared multi-cycle unit across NUM_LANES lanes and collects results.
// Optional per-lane WAIT timeout enabled by defining GPPCU_MC_TIMEOUT_EN.
module gppcu_mc_lane_sequencer #(
    parameter int NUM_LANES      = 4,
    parameter int DBW            = 32,
    parameter int OPC_BITS       = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                      iACLK,
    input logic                      iRST,
    gppcu_mc_lane_sequencer_if.slave bus
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                   state, state_nxt;
    logic [NUM_LANES-1:0]     pending, pending_nxt;
    logic [LW-1:0]            cur, cur_nxt;
    logic [NUM_LANES*DBW-1:0] opa_q, opb_q, opa_src, opb_src;
    logic [OPC_BITS-1:0]      opc_q;
    logic                     mc_start;
    logic [DBW-1:0]           mc_a, mc_b;
    logic [OPC_BITS-1:0]      mc_opc;
    logic [NUM_LANES*DBW-1:0] wb_q;
    logic [NUM_LANES-1:0]     wb_mask;
    logic                     accept, timeout_hit, lane_done;

    function automatic logic [LW-1:0] lowest_set(input logic [NUM_LANES-1:0] v);
        lowest_set = '0;
        for (int unsigned i = NUM_LANES; i > 0; i--)
            if (v[i-1]) lowest_set = LW'(i - 1);
    endfunction

    assign accept    = bus.iEXEC_VALID & bus.iEXEC_MCOP;
    assign lane_done = (state == WAIT) & (bus.iMC_DONE | timeout_hit);

    // Operands for the next issue come straight from the inputs when issuing out of IDLE,
    // because the latched copy is only written on that same edge.
    assign opa_src = (state == IDLE) ? bus.iOPR_A : opa_q;
    assign opb_src = (state == IDLE) ? bus.iOPR_B : opb_q;
    assign cur_nxt = lowest_set(pending_nxt);

    always_ff @(posedge iACLK) begin
        if (iRST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        unique case (state)
            IDLE: if (accept) begin
                pending_nxt = bus.iLANE_EN;
                state_nxt   = (bus.iLANE_EN == '0) ? DONE : ISSUE;
            end
            ISSUE: state_nxt = WAIT;
            WAIT: if (lane_done) begin
                pending_nxt = pending & ~(NUM_LANES'(1) << cur);
                state_nxt   = (pending_nxt == '0) ? DONE : ISSUE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.oBUSY = 1'b0;
        unique case (state)
            IDLE:        bus.oBUSY = accept;
            ISSUE, WAIT: bus.oBUSY = 1'b1;
            default:     bus.oBUSY = 1'b0;
        endcase
    end

    always_ff @(posedge iACLK) begin
        if (iRST) begin
            pending  <= '0;
            cur      <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            opc_q    <= '0;
            mc_start <= 1'b0;
            mc_a     <= '0;
            mc_b     <= '0;
            mc_opc   <= '0;
            wb_q     <= '0;
            wb_mask  <= '0;
        end else begin
            pending  <= pending_nxt;
            mc_start <= (state_nxt == ISSUE);
            if (state == IDLE && accept) begin
                opa_q   <= bus.iOPR_A;
                opb_q   <= bus.iOPR_B;
                opc_q   <= bus.iEXEC_OPC;
                wb_q    <= '0;
                wb_mask <= '0;
            end
            if (state_nxt == ISSUE) begin
                cur    <= cur_nxt;
                mc_a   <= opa_src[cur_nxt*DBW +: DBW];
                mc_b   <= opb_src[cur_nxt*DBW +: DBW];
                mc_opc <= (state == IDLE) ? bus.iEXEC_OPC : opc_q;
            end
            if (state == WAIT && bus.iMC_DONE) begin
                wb_q[cur*DBW +: DBW] <= bus.iMC_RESULT;
                wb_mask[cur]         <= 1'b1;
            end else if (timeout_hit) begin
                wb_q[cur*DBW +: DBW] <= '0;
                wb_mask[cur]         <= 1'b0;
            end
        end
    end

`ifdef GPPCU_MC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] timer;
    logic          timeout_q;

    assign timeout_hit = (state == WAIT) & ~bus.iMC_DONE & (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge iACLK) begin
        if (iRST) begin
            timer     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ISSUE)     timer <= '0;
            else if (state == WAIT) timer <= timer + 1'b1;
            if (timeout_hit) timeout_q <= 1'b1;
        end
    end

    assign bus.oTIMEOUT = timeout_q;
`else
    assign timeout_hit  = 1'b0;
    assign bus.oTIMEOUT = 1'b0;
`endif

    assign bus.oMC_START = mc_start;
    assign bus.oMC_A     = mc_a;
    assign bus.oMC_B     = mc_b;
    assign bus.oMC_OPC   = mc_opc;
    assign bus.oWB_Q     = wb_q;
    assign bus.oWB_MASK  = wb_mask;
endmodule
